// File: rtl/fp_addsub_sched_if.sv
// rtl/fp_addsub_sched_if.sv - requester, datapath-control and result signals of the FADD/FSUB scheduler
interface fp_addsub_sched_if #(
    parameter int NUM_STAGES = 3,
    parameter int TAG_W      = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [31:0]       req0_a;
    logic [31:0]       req0_b;
    logic              req0_sub;
    logic [TAG_W-1:0]  req0_tag;
    logic              req1_valid;
    logic              req1_ready;
    logic [31:0]       req1_a;
    logic [31:0]       req1_b;
    logic              req1_sub;
    logic [TAG_W-1:0]  req1_tag;
    logic              flush;
    logic [31:0]       dp_a;
    logic [31:0]       dp_b;
    logic              dp_add_sub;
    logic [NUM_STAGES-1:0] stage_en;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic              out_src;
    logic [3:0]        in_flight;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_tag,
        input  flush, out_ready,
        output req0_ready, req1_ready, dp_a, dp_b, dp_add_sub, stage_en,
        output out_valid, out_tag, out_src, in_flight, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_tag,
        output req1_valid, req1_a, req1_b, req1_sub, req1_tag,
        output flush, out_ready,
        input  req0_ready, req1_ready, dp_a, dp_b, dp_add_sub, stage_en,
        input  out_valid, out_tag, out_src, in_flight, busy
    );
endinterface

// File: rtl/fp_addsub_sched.sv
// rtl/fp_addsub_sched.sv - two-requester round-robin issue and stage sequencing for the shared FADD/FSUB pipe
module fp_addsub_sched #(
    parameter int NUM_STAGES = 3,
    parameter int TAG_W      = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    fp_addsub_sched_if.slave   bus
);
    localparam int N = NUM_STAGES;

    logic [N-1:0]     v_q, v_d;
    logic [N-1:0]     src_q, src_d;
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];
    logic             last_grant_q, last_grant_d;
    logic [3:0]       in_flight_q, in_flight_d;
    logic [N-1:0]     en;
    logic             hole;
    logic             grant, can_issue, accept;

    // A stage may load when it or any stage downstream of it has room.
    always_comb begin
        hole = bus.out_ready;
        en   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            hole  = hole | ~v_q[i];
            en[i] = hole;
        end
    end

    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
        else                                  grant = bus.req1_valid;
    end

    assign can_issue      = en[0] & ~bus.flush;
    assign accept         = can_issue & (bus.req0_valid | bus.req1_valid);
    assign bus.req0_ready = can_issue & ~grant;
    assign bus.req1_ready = can_issue & grant;
    assign bus.dp_a       = grant ? bus.req1_a   : bus.req0_a;
    assign bus.dp_b       = grant ? bus.req1_b   : bus.req0_b;
    assign bus.dp_add_sub = grant ? bus.req1_sub : bus.req0_sub;
    assign bus.stage_en   = en;

    always_comb begin
        v_d          = v_q;
        src_d        = src_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        for (int i = N - 1; i >= 1; i--) begin
            if (en[i]) begin
                v_d[i]   = v_q[i-1];
                src_d[i] = src_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
        if (en[0]) begin
            v_d[0] = accept;
            if (accept) begin
                src_d[0]     = grant;
                tag_d[0]     = grant ? bus.req1_tag : bus.req0_tag;
                last_grant_d = grant;
            end
        end
        // Flush kills every stage; tags are left as don't-care.
        if (bus.flush) v_d = '0;
        in_flight_d = 4'($countones(v_d));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q          <= '0;
            src_q        <= '0;
            last_grant_q <= 1'b1;
            in_flight_q  <= '0;
            for (int i = 0; i < N; i++) tag_q[i] <= '0;
        end else begin
            v_q          <= v_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            in_flight_q  <= in_flight_d;
            tag_q        <= tag_d;
        end
    end

    assign bus.out_valid = v_q[N-1];
    assign bus.out_tag   = tag_q[N-1];
    assign bus.out_src   = src_q[N-1];
    assign bus.in_flight = in_flight_q;
    assign bus.busy      = |in_flight_q;
endmodule

// File: tb/tb_fp_addsub_sched.sv
// tb/tb_fp_addsub_sched.sv - randomized and directed bench for fp_addsub_sched against an op-queue model
module tb_fp_addsub_sched;
    localparam int N  = 3;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fp_addsub_sched_if #(.NUM_STAGES(N), .TAG_W(TW)) bus();
    fp_addsub_sched #(.NUM_STAGES(N), .TAG_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Each in-flight op remembers which pipeline position it occupies.
    typedef struct {
        logic [TW-1:0] tag;
        logic          src;
        int            pos;
    } op_t;

    op_t           q[$];
    logic          m_last;
    logic [TW-1:0] seen[$];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit exp_ov();
        return q.size() > 0 && q[0].pos == N - 1;
    endfunction

    // Oldest op first: it retires or moves forward when the slot ahead is not kept by the op before it.
    task automatic advance_model(input bit ordy);
        op_t nq[$];
        op_t op;
        int  prev_pos;
        prev_pos = -1;
        foreach (q[k]) begin
            op = q[k];
            if (op.pos == N - 1 && ordy) begin
                prev_pos = -1;
            end else begin
                if (op.pos < N - 1 && prev_pos != op.pos + 1) op.pos++;
                nq.push_back(op);
                prev_pos = op.pos;
            end
        end
        q = nq;
    endtask

    task automatic drive(input bit v0, input logic [TW-1:0] t0, input bit v1, input logic [TW-1:0] t1);
        bus.req0_valid = v0;
        bus.req0_tag   = t0;
        bus.req0_a     = $urandom;
        bus.req0_b     = $urandom;
        bus.req0_sub   = 1'($urandom);
        bus.req1_valid = v1;
        bus.req1_tag   = t1;
        bus.req1_a     = $urandom;
        bus.req1_b     = $urandom;
        bus.req1_sub   = 1'($urandom);
    endtask

    // Entered at a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        bit  ce0, can, g, acc, ov;
        op_t nop;
        #2;
        ov  = exp_ov();
        ce0 = !(q.size() == N && !bus.out_ready);
        can = ce0 && !bus.flush;
        g   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        acc = can && (bus.req0_valid || bus.req1_valid);
        chk("ready0", 32'(bus.req0_ready), 32'(can && !g));
        chk("ready1", 32'(bus.req1_ready), 32'(can && g));
        chk("en0", 32'(bus.stage_en[0]), 32'(ce0));
        chk("en_last", 32'(bus.stage_en[N-1]), 32'(!ov || bus.out_ready));
        chk("dp_a", bus.dp_a, g ? bus.req1_a : bus.req0_a);
        chk("dp_b", bus.dp_b, g ? bus.req1_b : bus.req0_b);
        chk("dp_add_sub", 32'(bus.dp_add_sub), 32'(g ? bus.req1_sub : bus.req0_sub));
        chk("ov_pre", 32'(bus.out_valid), 32'(ov));
        if (ov && bus.out_ready) seen.push_back(q[0].tag);
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
        end else begin
            advance_model(bus.out_ready);
            if (acc) begin
                nop.tag = g ? bus.req1_tag : bus.req0_tag;
                nop.src = g;
                nop.pos = 0;
                q.push_back(nop);
                m_last = g;
            end
        end
        #1;
        ov = exp_ov();
        chk("out_valid", 32'(bus.out_valid), 32'(ov));
        if (ov) begin
            chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
            chk("out_src", 32'(bus.out_src), 32'(q[0].src));
        end
        chk("in_flight", 32'(bus.in_flight), 32'(q.size()));
        chk("busy", 32'(bus.busy), 32'(q.size() != 0));
        @(negedge clk);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0);
        m_last = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_flight", 32'(bus.in_flight), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stage_en", 32'(bus.stage_en), 32'h7);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single op with 3-cycle latency.
        drive(1, 5, 0, 0);
        bus.req0_a   = 32'h3F80_0000;
        bus.req0_b   = 32'h4000_0000;
        bus.req0_sub = 1'b0;
        #1;
        chk("single_ready", 32'(bus.req0_ready), 32'd1);
        chk("single_dp_a", bus.dp_a, 32'h3F80_0000);
        chk("single_dp_b", bus.dp_b, 32'h4000_0000);
        tick();
        chk("single_inflight1", 32'(bus.in_flight), 32'd1);
        drive(0, 0, 0, 0);
        tick();
        chk("single_early", 32'(bus.out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_tag", 32'(bus.out_tag), 32'd5);
        chk("single_src", 32'(bus.out_src), 32'd0);
        tick();
        chk("single_inflight0", 32'(bus.in_flight), 32'd0);

        // Backpressure: fill with 10,11,12 while the consumer stalls.
        bus.out_ready = 1'b0;
        for (int t = 10; t <= 12; t++) begin
            drive(1, 5'(t), 0, 0);
            tick();
        end
        drive(1, 13, 0, 0);
        #1;
        chk("bp_stage_en", 32'(bus.stage_en), 32'd0);
        chk("bp_ready", 32'(bus.req0_ready), 32'd0);
        tick();
        tick();
        chk("bp_hold_tag", 32'(bus.out_tag), 32'd10);
        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_ret11", 32'(bus.out_tag), 32'd11);
        tick();
        chk("bp_ret12", 32'(bus.out_tag), 32'd12);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Bubble collapse: tag 4 closes up behind a stalled tag 3.
        drive(1, 3, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        drive(1, 4, 0, 0);
        bus.out_ready = 1'b0;
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("bub_in_flight", 32'(bus.in_flight), 32'd2);
        chk("bub_out_tag", 32'(bus.out_tag), 32'd3);
        chk("bub_stage_en", 32'(bus.stage_en), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Flush with three ops in flight.
        for (int t = 20; t <= 22; t++) begin
            drive(1, 5'(t), 0, 0);
            tick();
        end
        drive(1, 23, 0, 0);
        bus.flush = 1'b1;
        #1;
        chk("flush_ready", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_flight", 32'(bus.in_flight), 32'd0);
        drive(1, 24, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("postflush_valid", 32'(bus.out_valid), 32'd1);
        chk("postflush_tag", 32'(bus.out_tag), 32'd24);
        tick();

        // Asynchronous reset with two ops in flight.
        drive(1, 7, 0, 0);
        tick();
        drive(1, 8, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        q.delete();
        m_last = 1'b1;
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Contention right after reset: grants 0,1,0,1 and results in order.
        seen.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 2);
            #1;
            chk("cont_grant0", 32'(bus.req0_ready), 32'(k % 2 == 0));
            tick();
        end
        drive(0, 0, 0, 0);
        repeat (4) tick();
        chk("cont_count", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk("cont_order", 32'(seen[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

        // Randomized traffic against the op-queue model.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)), 5'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_sched.md
Name: fp_addsub_sched

Overview:
- Issue scheduler and pipeline sequencer for the shared single-precision FADD/FSUB datapath: extract/align, add/normalize, round.
- Arbitrates between two requesters, requester 0 being the core FP issue path and requester 1 the secondary FP client such as the convert/compare helper. Round-robin arbitration.
- Muxes the granted operands into datapath stage 0.
- Generates per-stage register enables with bubble collapsing and backpressure.
- Tracks tag/source per stage; supports flush.

Parameters:
- NUM_STAGES, 3, number of datapath register stages (min 1, max 8)
- TAG_W, 5, width of requester tag (e.g. destination register index)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req0_a  in  32  requester 0 operand 1 (IEEE-754 single)
- req0_b  in  32  requester 0 operand 2
- req0_sub  in  1  requester 0: 1=subtract, 0=add
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid, req1_ready, req1_a, req1_b, req1_sub, req1_tag  same as requester 0, for requester 1
- flush  in  1  kill all in-flight ops and block issue this cycle
- dp_a  out  32  operand 1 to datapath stage 0
- dp_b  out  32  operand 2 to datapath stage 0
- dp_add_sub  out  1  op select to datapath stage 0
- stage_en  out  NUM_STAGES  register enable for datapath stage i
- out_valid  out  1  result in last stage is valid
- out_ready  in  1  consumer accepts result
- out_tag  out  TAG_W  tag of result in last stage
- out_src  out  1  requester id of result in last stage
- in_flight  out  4  count of valid stages
- busy  out  1  in_flight != 0

Behaviour:
- Reset, asynchronous on reset_n low:
  - all stage valid bits, tags and src bits cleared; out_valid=0; in_flight=0; busy=0.
  - last_grant=1, so requester 0 wins first contention.
- Stage valid bits v[0..N-1]; stage N-1 is the output stage.
- Stage enables:
  - en[N-1] = !v[N-1] | out_ready
  - en[i] = !v[i] | en[i+1]
  - An empty stage always accepts (bubble collapsing).
  - stage_en = en, combinational.
- Issue:
  - can_issue = en[0] & !flush.
  - Grant is combinational. If only one requester is valid, it wins. If both are valid, grant goes to the one not equal to last_grant.
  - reqX_ready = can_issue & grant==X. Ready never depends on its own valid except through arbitration.
  - On accept: v[0]<=1, tag0<=granted tag, src0<=granted id, last_grant<=granted id.
  - On an en[0] cycle with no accept: v[0]<=0.
- Operand mux:
  - dp_a, dp_b and dp_add_sub always reflect the granted requester.
  - With no request, they reflect requester 0 values. The datapath captures them only when stage_en[0]=1.
- Advance: when en[i] is set for i>0, v/tag/src of stage i <= stage i-1. A stage with en=0 holds its contents.
- Output:
  - out_valid=v[N-1]; out_tag/out_src come from stage N-1.
  - A result is retired when out_valid & out_ready.
  - While out_ready=0, out_valid, out_tag and out_src stay stable.
- Latency: accept at cycle T gives out_valid at T+NUM_STAGES with no stall. Throughput is 1 op/cycle.
- Flush:
  - At the next edge, every v bit is cleared regardless of enables.
  - Any same-cycle accept is blocked because ready=0.
  - out_valid may be high during the flush cycle; the consumer must ignore it.
  - Tags are don't-care after flush.
- in_flight: registered popcount of v, updated with v. It is 0 one cycle after a flush.
- Simultaneous accept and retire with the pipeline full: allowed. in_flight stays unchanged.
- The fixed datapath has no NaN/inf sequencing; special-case handling stays inside the datapath. The scheduler is purely control.

Test Plan:
- Single op: after reset, req0 a=0x3F800000, b=0x40000000, sub=0, tag=5. Required: req0_ready=1 same cycle; dp_a/dp_b equal the operands; out_valid=1 with out_tag=5, out_src=0 exactly 3 cycles later; in_flight goes 1 then 0.
- Contention: both requesters are valid for 4 consecutive cycles with tags 1 (req0) and 2 (req1). Required: grants alternate 0,1,0,1; outputs in order tag 1,2,1,2.
- Backpressure: fill the pipe with tags 10,11,12 and hold out_ready=0. Required: stage_en=000 and req ready=0; out_tag held at 10. Release out_ready: tags 10,11,12 retire on consecutive cycles.
- Bubble collapse: issue tag 3, idle 2 cycles, issue tag 4, with out_ready=0 from tag 3's arrival. Required: tag 4 advances to stage N-2 while stage N-1 holds 3; in_flight=2.
- Flush: 3 ops in flight and req0 valid, assert flush for 1 cycle. Required: req0_ready=0 that cycle; next cycle out_valid=0 and in_flight=0; a subsequent issue gives its output 3 cycles later.
- Async reset mid-operation: drop reset_n between clock edges with 2 ops in flight. Required: out_valid=0 and busy=0 immediately; after release, first contention grants requester 0.
